// File: rtl/disk_ii_ctrl_p.sv
// Disk II style floppy controller: soft-switch decode, stepper head positioning,
// nibble timing against a flat track-image memory, and motor run-on.

module disk_ii_stepper #(
  parameter int HT_MAX = 68
) (
  input  logic       en,
  input  logic [3:0] phase,
  input  logic [6:0] ht,
  output logic [6:0] ht_nxt
);
  logic [1:0] m, k;
  always_comb begin
    m = ht[1:0];
    k = 2'd0;
    for (int i = 0; i < 4; i++) if (phase[i]) k = 2'(i);
    ht_nxt = ht;
    // Only a single energised phase adjacent to the current one pulls the head.
    if (en && $onehot(phase)) begin
      if (k == m + 2'd1 && ht < 7'(HT_MAX))  ht_nxt = ht + 7'd1;
      else if (k == m - 2'd1 && ht != 7'd0) ht_nxt = ht - 7'd1;
    end
  end
endmodule

module disk_ii_ctrl_p #(
  parameter int SLOT        = 6,
  parameter int NUM_TRACKS  = 35,
  parameter int TRACK_BYTES = 6656,
  parameter int BYTE_CYCLES = 32,
  parameter int MOTOR_DELAY = 1000000,
  parameter int AW          = 18
) (
  input  logic          PH_2,
  input  logic          RESET_N,
  input  logic [15:0]   ADDRESS,
  input  logic          ADDR_VALID,
  input  logic [7:0]    DATA_OUT,
  output logic [7:0]    FLOPPY_DATA,
  input  logic [7:0]    FLOPPY_DATA_IN,
  output logic [AW-1:0] FLOPPY_ADDRESS,
  output logic [7:0]    FLOPPY_WR_DATA,
  output logic          FLOPPY_WE,
  input  logic [1:0]    WP,
  output logic [1:0]    DRIVE_ACTIVE,
  output logic [6:0]    HALF_TRACK
);
  localparam logic [11:0] IO_BASE = 12'(12'hC08 + SLOT);
  localparam int HT_MAX = 2 * NUM_TRACKS - 2;
  localparam int BTW    = BYTE_CYCLES > 1 ? $clog2(BYTE_CYCLES) : 1;
  localparam int BPW    = TRACK_BYTES > 1 ? $clog2(TRACK_BYTES) : 1;
  localparam int RW     = MOTOR_DELAY > 0 ? $clog2(MOTOR_DELAY + 1) : 1;

  logic [3:0]      phase_q, phase_d;
  logic            spin_q, spin_d, sel2_q, sel2_d;
  logic            q6_q, q6_d, q7_q, q7_d, valid_q, valid_d;
  logic [RW-1:0]   runon_q, runon_d;
  logic [7:0]      latch_q, latch_d, wreg_q, wreg_d;
  logic [BTW-1:0]  btmr_q, btmr_d;
  logic [BPW-1:0]  bpos_q, bpos_d;
  logic [1:0][6:0] ht_q, ht_d, ht_step;
  logic [6:0]      ht_sel;
  logic [3:0]      off;
  logic            hit, tick;

  assign off    = ADDRESS[3:0];
  assign hit    = ADDR_VALID && (ADDRESS[15:4] == IO_BASE);
  assign tick   = spin_q && (btmr_q == BTW'(BYTE_CYCLES - 1));
  assign ht_sel = ht_q[sel2_q];

  for (genvar d = 0; d < 2; d++) begin : g_drv
    disk_ii_stepper #(.HT_MAX(HT_MAX)) u_step (
      .en     (spin_q && ((d == 1) ? sel2_q : !sel2_q)),
      .phase  (phase_q),
      .ht     (ht_q[d]),
      .ht_nxt (ht_step[d])
    );
  end

  always_comb begin
    phase_d = phase_q;
    spin_d  = spin_q;
    runon_d = runon_q;
    sel2_d  = sel2_q;
    q6_d    = q6_q;
    q7_d    = q7_q;
    valid_d = valid_q;
    latch_d = latch_q;
    wreg_d  = wreg_q;
    btmr_d  = btmr_q;
    bpos_d  = bpos_q;
    ht_d    = ht_step;
    if (runon_q != '0) begin
      runon_d = runon_q - 1'b1;
      if (runon_q == RW'(1)) spin_d = 1'b0;
    end
    if (spin_q) btmr_d = tick ? '0 : btmr_q + 1'b1;
    if (tick) bpos_d = (bpos_q == BPW'(TRACK_BYTES - 1)) ? '0 : bpos_q + 1'b1;
    // A fresh nibble arriving in the same cycle as a read keeps VALID set.
    if (hit && off == 4'hC && !q7_q) valid_d = 1'b0;
    if (tick && !q7_q) begin
      latch_d = FLOPPY_DATA_IN;
      valid_d = 1'b1;
    end
    if (hit) begin
      case (off)
        4'h0, 4'h1, 4'h2, 4'h3,
        4'h4, 4'h5, 4'h6, 4'h7: phase_d[off[2:1]] = off[0];
        4'h8: if (spin_q) begin
          runon_d = RW'(MOTOR_DELAY);
          spin_d  = (MOTOR_DELAY != 0);
        end
        4'h9: begin
          spin_d  = 1'b1;
          runon_d = '0;
        end
        4'hA: sel2_d = 1'b0;
        4'hB: sel2_d = 1'b1;
        4'hC: q6_d = 1'b0;
        4'hD: begin
          q6_d = 1'b1;
          if (q7_q) wreg_d = DATA_OUT;
        end
        4'hE: q7_d = 1'b0;
        4'hF: q7_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge PH_2 or negedge RESET_N) begin
    if (!RESET_N) begin
      phase_q <= '0;
      spin_q  <= 1'b0;
      runon_q <= '0;
      sel2_q  <= 1'b0;
      q6_q    <= 1'b0;
      q7_q    <= 1'b0;
      valid_q <= 1'b0;
      latch_q <= '0;
      wreg_q  <= '0;
      btmr_q  <= '0;
      bpos_q  <= '0;
      ht_q    <= '0;
    end else begin
      phase_q <= phase_d;
      spin_q  <= spin_d;
      runon_q <= runon_d;
      sel2_q  <= sel2_d;
      q6_q    <= q6_d;
      q7_q    <= q7_d;
      valid_q <= valid_d;
      latch_q <= latch_d;
      wreg_q  <= wreg_d;
      btmr_q  <= btmr_d;
      bpos_q  <= bpos_d;
      ht_q    <= ht_d;
    end
  end

  always_comb begin
    FLOPPY_DATA = 8'h00;
    if (RESET_N && hit && !q7_q) begin
      if (off == 4'hC)            FLOPPY_DATA = {latch_q[7] & valid_q, latch_q[6:0]};
      else if (off == 4'hE && q6_q) FLOPPY_DATA = {WP[sel2_q], 7'h00};
    end
  end

  // Write strobe is combinational so the address seen is the pre-advance position.
  assign FLOPPY_WE      = RESET_N && tick && q7_q && !WP[sel2_q];
  assign FLOPPY_WR_DATA = wreg_q;
  assign FLOPPY_ADDRESS = AW'(32'(ht_sel[6:1]) * TRACK_BYTES + 32'(bpos_q));
  assign DRIVE_ACTIVE   = {spin_q & sel2_q, spin_q & ~sel2_q};
  assign HALF_TRACK     = ht_sel;
endmodule
